// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the divider front-end: op codes, FSM states,
// special-case operand constants and the one-entry result cache layout.
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } div_state_e;

    localparam logic [31:0] MIN_NEG  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    typedef struct packed {
        logic        vld;
        logic        sgn;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] res;
        logic [31:0] rem;
    } cache_t;

    // op[1] selects the remainder, otherwise the quotient
    function automatic logic [31:0] sel_result(input logic rem_op,
                                               input logic [31:0] q,
                                               input logic [31:0] r);
        return rem_op ? r : q;
    endfunction

endpackage

// File: rtl/div_ctrl.sv
// Front-end for an external iterative divider: handshakes requests, resolves
// divide-by-zero, signed overflow and repeat operands locally, and handles flush.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int CACHE_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        div_valid,
    input  logic        div_ready,
    output logic        div_sign,
    output logic [31:0] div1,
    output logic [31:0] div2,
    input  logic [31:0] res,
    input  logic [31:0] rem,
    input  logic        div_outvalid
);

    div_state_e  state;
    cache_t      cache;
    logic        rem_sel;

    logic        sgn;
    logic        dz;
    logic        ovf;
    logic        hit;
    logic [31:0] fast_q;
    logic [31:0] fast_r;

    assign in_ready = (state == S_IDLE);

    always_comb begin
        sgn    = ~op[0];
        dz     = (src2 == '0);
        ovf    = sgn && (src1 == MIN_NEG) && (src2 == ALL_ONES);
        hit    = (CACHE_EN != 0) && cache.vld && (cache.src1 == src1) &&
                 (cache.src2 == src2) && (cache.sgn == sgn);
        // zero divisor wins over overflow: both are fixed by the ISA
        fast_q = dz ? ALL_ONES : (ovf ? MIN_NEG : cache.res);
        fast_r = dz ? src1     : (ovf ? '0      : cache.rem);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= S_IDLE;
            cache     <= '0;
            rem_sel   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            div_valid <= 1'b0;
            div_sign  <= 1'b0;
            div1      <= '0;
            div2      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && !flush) begin
                        rem_sel <= op[1];
                        if (dz || ovf || hit) begin
                            out_data  <= sel_result(op[1], fast_q, fast_r);
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            div_valid <= 1'b1;
                            div1      <= src1;
                            div2      <= src2;
                            div_sign  <= sgn;
                            state     <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        // a same-cycle handshake still owes us a result to swallow
                        div_valid <= 1'b0;
                        state     <= div_ready ? S_DRAIN : S_IDLE;
                    end else if (div_ready) begin
                        div_valid <= 1'b0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state <= div_outvalid ? S_IDLE : S_DRAIN;
                    end else if (div_outvalid) begin
                        out_data   <= sel_result(rem_sel, res, rem);
                        out_valid  <= 1'b1;
                        cache.vld  <= 1'b1;
                        cache.sgn  <= div_sign;
                        cache.src1 <= div1;
                        cache.src2 <= div2;
                        cache.res  <= res;
                        cache.rem  <= rem;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (div_outvalid) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: behavioural divider with stallable ready and variable
// latency, expected results queued at request time and compared on output.
module tb_div_ctrl;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        div_valid;
    logic        div_ready;
    logic        div_sign;
    logic [31:0] div1;
    logic [31:0] div2;
    logic [31:0] res;
    logic [31:0] rem;
    logic        div_outvalid;

    int          tests;
    int          fails;
    int          hs_count;
    int          rdy_stall;
    int          div_lat;
    logic [31:0] exp_q[$];

    div_ctrl #(.CACHE_EN(1)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .src1(src1), .src2(src2), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .div_valid(div_valid), .div_ready(div_ready), .div_sign(div_sign),
        .div1(div1), .div2(div2), .res(res), .rem(rem),
        .div_outvalid(div_outvalid)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached with %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

    // Behavioural divider, stepped 1 time unit after each rising edge.
    initial begin : divider
        bit          hs_pend;
        bit          busy;
        int          cnt;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        hs_pend = 0; busy = 0; cnt = 0; a = '0; b = '0; s = 1'b0;
        div_ready = 1'b0; div_outvalid = 1'b0; res = '0; rem = '0;
        forever begin
            @(posedge clock);
            #1;
            div_outvalid = 1'b0;
            if (hs_pend) begin
                hs_pend = 0; busy = 1; cnt = div_lat;
            end
            if (busy) begin
                if (cnt == 0) begin
                    busy = 0;
                    div_outvalid = 1'b1;
                    if (s) begin
                        res = $signed(a) / $signed(b);
                        rem = $signed(a) % $signed(b);
                    end else begin
                        res = a / b;
                        rem = a % b;
                    end
                end else begin
                    cnt--;
                end
            end
            if (div_valid && !busy && !hs_pend) begin
                if (rdy_stall > 0) begin
                    div_ready = 1'b0;
                    rdy_stall--;
                end else begin
                    div_ready = 1'b1;
                    hs_pend = 1;
                    hs_count++;
                    a = div1; b = div2; s = div_sign;
                end
            end else begin
                div_ready = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit push, input logic [31:0] e);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("req_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; op = o; src1 = a; src2 = b;
        @(negedge clock);
        in_valid = 1'b0;
        if (push) exp_q.push_back(e);
    endtask

    task automatic get_resp(input string tag, input int stall);
        int          n;
        logic [31:0] held;
        logic [31:0] e;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
            held = out_data;
            for (int i = 0; i < stall; i++) begin
                @(negedge clock);
                chk({tag, "_hold_vld"}, {31'd0, out_valid}, 32'd1);
                chk({tag, "_hold_data"}, out_data, held);
            end
            out_ready = 1'b1;
            chk({tag, "_sb_size"}, exp_q.size(), 32'd1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk({tag, "_data"}, out_data, e);
            @(negedge clock);
            out_ready = 1'b0;
            chk({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic wait_wait_state(input string tag);
        int n;
        n = 0;
        while (div_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_issued"}, {31'd0, div_valid}, 32'd0);
    endtask

    initial begin : main
        int hs0;
        int n;
        int d;
        tests = 0; fails = 0; hs_count = 0; rdy_stall = 0; div_lat = 2;
        reset = 1'b0; in_valid = 1'b0; op = 2'b00; src1 = '0; src2 = '0;
        flush = 1'b0; out_ready = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_div_valid", {31'd0, div_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_out_data",  out_data, 32'd0);
        chk("rst_div1",      div1, 32'd0);
        chk("rst_div2",      div2, 32'd0);
        chk("rst_div_sign",  {31'd0, div_sign}, 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // request under flush is dropped
        in_valid = 1'b1; op = 2'b01; src1 = 32'd9; src2 = 32'd3; flush = 1'b1;
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_rdy", {31'd0, in_ready}, 32'd1);
        chk("idle_flush_dv",  {31'd0, div_valid}, 32'd0);
        chk("idle_flush_ov",  {31'd0, out_valid}, 32'd0);

        // DIV -20/3 through the divider, then REM of the same from the cache
        hs0 = hs_count;
        do_req(2'b00, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFA);
        get_resp("div_m20_3", 0);
        chk("div_m20_3_hs", hs_count - hs0, 32'd1);
        hs0 = hs_count;
        do_req(2'b10, 32'hFFFF_FFEC, 32'd3, 1, 32'hFFFF_FFFE);
        chk("rem_hit_lat", {31'd0, out_valid}, 32'd1);
        get_resp("rem_m20_3", 0);
        chk("rem_hit_hs", hs_count - hs0, 32'd0);

        // divide by zero and signed overflow fast paths
        hs0 = hs_count;
        do_req(2'b01, 32'd7, 32'd0, 1, 32'hFFFF_FFFF);
        chk("divu_z_lat", {31'd0, out_valid}, 32'd1);
        get_resp("divu_7_0", 0);
        do_req(2'b11, 32'd7, 32'd0, 1, 32'd7);
        get_resp("remu_7_0", 0);
        do_req(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000);
        get_resp("div_ovf", 0);
        do_req(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0);
        get_resp("rem_ovf", 0);
        chk("fast_hs", hs_count - hs0, 32'd0);

        // divider back-pressure: operands held while div_ready is low
        hs0 = hs_count;
        rdy_stall = 5;
        do_req(2'b01, 32'd100, 32'd7, 1, 32'd14);
        n = 0;
        while (div_valid && n < 50) begin
            chk("stall_div1", div1, 32'd100);
            chk("stall_div2", div2, 32'd7);
            chk("stall_sign", {31'd0, div_sign}, 32'd0);
            @(negedge clock);
            n++;
        end
        chk("stall_cycles", n, 32'd6);
        get_resp("divu_100_7", 3);
        chk("stall_hs", hs_count - hs0, 32'd1);

        // replace the cached entry so 100/7 is no longer present
        do_req(2'b01, 32'd1000, 32'd9, 1, 32'd111);
        get_resp("divu_1000_9", 0);

        // flush in WAIT: result must be drained and not cached
        div_lat = 6;
        do_req(2'b01, 32'd100, 32'd7, 0, 32'd0);
        wait_wait_state("drain");
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        n = 0;
        while (!div_outvalid && n < 50) begin
            chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
            chk("drain_out_valid", {31'd0, out_valid}, 32'd0);
            @(negedge clock);
            n++;
        end
        chk("drain_seen", {31'd0, div_outvalid}, 32'd1);
        @(negedge clock);
        chk("drain_idle", {31'd0, in_ready}, 32'd1);
        chk("drain_no_out", {31'd0, out_valid}, 32'd0);
        div_lat = 2;
        hs0 = hs_count;
        do_req(2'b11, 32'd100, 32'd7, 1, 32'd2);
        get_resp("remu_100_7", 0);
        chk("no_pollute_hs", hs_count - hs0, 32'd1);

        // flush in DONE drops the pending result
        do_req(2'b11, 32'd7, 32'd0, 0, 32'd0);
        chk("done_flush_pre", {31'd0, out_valid}, 32'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("done_flush_ov", {31'd0, out_valid}, 32'd0);
        chk("done_flush_rdy", {31'd0, in_ready}, 32'd1);

        // reset in WAIT; the divider finishes afterwards and must be ignored
        div_lat = 8;
        do_req(2'b01, 32'd55, 32'd5, 0, 32'd0);
        wait_wait_state("rstw");
        d = hs_count;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("rstw_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rstw_in_ready",  {31'd0, in_ready},  32'd1);
        n = 0;
        while (!div_outvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("rstw_stray_seen", {31'd0, div_outvalid}, 32'd1);
        @(negedge clock);
        chk("stray_out_valid", {31'd0, out_valid}, 32'd0);
        chk("stray_in_ready",  {31'd0, in_ready},  32'd1);
        chk("stray_div_valid", {31'd0, div_valid}, 32'd0);
        chk("stray_no_hs", hs_count - d, 32'd0);

        // cache was cleared by reset, so this repeat goes to the divider
        div_lat = 1;
        hs0 = hs_count;
        do_req(2'b01, 32'd55, 32'd5, 1, 32'd11);
        get_resp("divu_55_5", 0);
        chk("post_rst_hs", hs_count - hs0, 32'd1);

        chk("sb_left", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
